// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared defaults and state encoding for the program RAM loader.
//   ADDR_W_DEF / DATA_W_DEF / DEPTH_DEF : default geometry (16 x 8 RAM).
//   LOAD_CYCLES_PER_BYTE                : cycles per byte with input held valid.
//   loader_state_t                      : 3-bit FSM state encoding.
package ram_loader_pkg;
  localparam int ADDR_W_DEF           = 4;
  localparam int DATA_W_DEF           = 8;
  localparam int DEPTH_DEF            = 16;
  localparam int LOAD_CYCLES_PER_BYTE = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_LOAD_MAR  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READBACK  = 3'd4,
    ST_CHECK     = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } loader_state_t;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: bus initiator that fills the program RAM before the CPU runs.
// Each byte taken over in_valid/in_ready is addressed through the MAR, written,
// read back and compared. The CPU is held off the bus until a run succeeds.
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   start             begin a run (ignored while busy)
//   in_data/in_valid/in_ready  byte stream handshake
//   mar_addr, mar_wr  memory address register input and load strobe
//   data              shared RAM bus, driven only in WRITE
//   ram_wr, ram_en    RAM write strobe / output enable
//   cpu_hold, busy    CPU hold-off, run in progress
//   done, verify_err, err_addr  sticky run status, first mismatch address
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_wr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ram_wr,
  output logic              ram_en,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      rd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    rd_d       = rd_q;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_WAIT_BYTE;
          cnt_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      ST_WAIT_BYTE: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = ST_LOAD_MAR;
        end
      end
      ST_LOAD_MAR: state_d = ST_WRITE;
      ST_WRITE:    state_d = ST_READBACK;
      ST_READBACK: begin
        // RAM drives the bus this cycle; capture it at the closing edge
        rd_d    = data;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (rd_q != byte_q) begin
          err_d      = 1'b1;
          err_addr_d = cnt_q;
          state_d    = ST_ERROR;
        end else if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WAIT_BYTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are pure state decodes, so they are mutually exclusive by construction
  assign in_ready   = (state_q == ST_WAIT_BYTE);
  assign mar_wr     = (state_q == ST_LOAD_MAR);
  assign ram_wr     = (state_q == ST_WRITE);
  assign ram_en     = (state_q == ST_READBACK);
  assign mar_addr   = (mar_wr || ram_wr || ram_en) ? cnt_q : '0;
  assign busy       = (state_q == ST_WAIT_BYTE) || (state_q == ST_LOAD_MAR) ||
                      (state_q == ST_WRITE)     || (state_q == ST_READBACK) ||
                      (state_q == ST_CHECK);
  // Only a successful run releases the CPU; reset and errors keep it held
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = done_q;
  assign verify_err = err_q;
  assign err_addr   = err_addr_q;

  assign data = (state_q == ST_WRITE) ? byte_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int AW = 4, DW = 8, DEPTH = 16;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mar_wr, ram_wr, ram_en, cpu_hold, busy, done, verify_err;
  logic [AW-1:0] mar_addr, err_addr;
  wire  [DW-1:0] data;

  int checks = 0;
  int errors = 0;

  // RAM model: registered MAR, write on ram_wr, drive bus on ram_en
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mar_q = '0;
  logic          bad_en = 1'b0;
  logic [AW-1:0] bad_addr = '0;
  logic [DW-1:0] stim [DEPTH];
  logic          mon_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (data[g]);
  end

  assign data = ram_en ? ((bad_en && mar_q == bad_addr) ? 8'hFF : mem[mar_q]) : 'z;

  always @(posedge clk) begin
    if (mar_wr) mar_q <= mar_addr;
    if (ram_wr) mem[mar_q] <= data;
  end

  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mar_addr(mar_addr), .mar_wr(mar_wr), .data(data),
    .ram_wr(ram_wr), .ram_en(ram_en), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .verify_err(verify_err), .err_addr(err_addr)
  );

  // Bus ownership rules, checked every cycle while enabled
  always @(negedge clk) begin
    if (rst && mon_en) begin
      checks++;
      if ((ram_wr && ram_en) || (mar_wr && ram_wr) ||
          (in_ready && (mar_wr || ram_wr || ram_en))) begin
        errors++;
        $display("FAIL strobe_excl: in_ready=%b mar_wr=%b ram_wr=%b ram_en=%b, required one-hot",
                 in_ready, mar_wr, ram_wr, ram_en);
      end
      if (!ram_wr && !ram_en) begin
        checks++;
        if (data !== 8'hFF) begin
          errors++;
          $display("FAIL bus_release: data=%h while idle, required released (pulled FF)", data);
        end
      end
    end
  end

  task automatic drive_run(input bit toggle, input int start_mid, input int rst_at,
                           output int cycles, output int acc, output bit aborted);
    int idx;
    bit mid_done;
    idx = 0; acc = 0; cycles = 0; aborted = 0; mid_done = 0;
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done || verify_err) break;
      if (rst_at >= 0 && ram_wr && mar_addr == AW'(rst_at)) begin
        #1 rst = 1'b0;
        aborted = 1;
        break;
      end
      if (cycles > BUDGET) begin
        checks++; errors++;
        $display("FAIL run_timeout: %0d cycles without done/verify_err, required <= %0d", cycles, BUDGET);
        break;
      end
      start = (start_mid >= 0 && idx == start_mid && !mid_done);
      if (start) mid_done = 1;
      in_valid = (idx < DEPTH) && (!toggle || cycles[0]);
      in_data  = (idx < DEPTH) ? stim[idx] : 8'h00;
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      cycles++;
    end
    start = 1'b0; in_valid = 1'b0;
    acc = idx;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: hold=%b busy=%b done=%b rdy=%b, required 1 0 0 0",
               cpu_hold, busy, done, in_ready);
    end
    checks++;
    if (mar_wr !== 1'b0 || ram_wr !== 1'b0 || ram_en !== 1'b0 || verify_err !== 1'b0 ||
        mar_addr !== 4'd0 || err_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_strobes: mar_wr=%b ram_wr=%b ram_en=%b verr=%b mar=%0d ea=%0d, required all 0",
               mar_wr, ram_wr, ram_en, verify_err, mar_addr, err_addr);
    end
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_bus: data=%h, required released", data);
    end
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic check_image(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[i] !== stim[i]) begin
        errors++;
        $display("FAIL %s_ram[%0d]: got %h, required %h", name, i, mem[i], stim[i]);
      end
    end
  endtask

  task automatic check_done(input string name, input int cycles, input int exp_cycles, input int acc);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || verify_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: done=%b hold=%b busy=%b verr=%b, required 1 0 0 0",
               name, done, cpu_hold, busy, verify_err);
    end
    checks++;
    if (cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s_cycles: got %0d, required %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (acc != DEPTH) begin
      errors++;
      $display("FAIL %s_accepted: got %0d bytes, required %0d", name, acc, DEPTH);
    end
  endtask

  task automatic test_stream();
    int cyc, acc;
    bit ab;
    logic [DW-1:0] hdr [6];
    hdr = '{8'h40, 8'h61, 8'h85, 8'hE0, 8'h51, 8'hF0};
    for (int i = 0; i < DEPTH; i++) stim[i] = (i < 6) ? hdr[i] : 8'h00;
    drive_run(1'b0, -1, -1, cyc, acc, ab);
    check_done("stream", cyc, DEPTH * LOAD_CYCLES_PER_BYTE, acc);
    check_image("stream", DEPTH);
  endtask

  task automatic test_throttled();
    int cyc, acc, t;
    bit ab;
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
    // in_valid is high on odd cycles after start; each byte waits for one, then takes 5
    t = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (t % 2 == 0) t++;
      t += LOAD_CYCLES_PER_BYTE;
    end
    drive_run(1'b1, -1, -1, cyc, acc, ab);
    check_done("throttle", cyc, t, acc);
    check_image("throttle", DEPTH);
  endtask

  task automatic test_verify_err();
    int cyc, acc;
    bit ab;
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom_range(0, 254));
    bad_en = 1'b1; bad_addr = 4'd3;
    drive_run(1'b0, -1, -1, cyc, acc, ab);
    checks++;
    if (verify_err !== 1'b1 || err_addr !== 4'd3 || done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL verr_status: verr=%b ea=%0d done=%b hold=%b busy=%b, required 1 3 0 1 0",
               verify_err, err_addr, done, cpu_hold, busy);
    end
    checks++;
    if (cyc != 4 * LOAD_CYCLES_PER_BYTE || acc != 4) begin
      errors++;
      $display("FAIL verr_timing: cycles=%0d acc=%0d, required %0d 4", cyc, acc, 4 * LOAD_CYCLES_PER_BYTE);
    end
    // ERROR must hold: no further bytes taken
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || verify_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL verr_hold: rdy=%b verr=%b busy=%b, required 0 1 0", in_ready, verify_err, busy);
    end
    in_valid = 1'b0;
    bad_en = 1'b0;
    check_image("verr", 4);
  endtask

  task automatic test_reset_mid();
    int cyc, acc;
    bit ab;
    logic [DW-1:0] pre7;
    pre7 = mem[7];
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom_range(0, 254));
    stim[7] = (pre7 == 8'h5A) ? 8'hA5 : 8'h5A;
    drive_run(1'b0, -1, 7, cyc, acc, ab);
    #1;
    checks++;
    if (!ab || data !== 8'hFF || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: hit=%b data=%h busy=%b hold=%b done=%b wr=%b, required 1 FF 0 1 0 0",
               ab, data, busy, cpu_hold, done, ram_wr);
    end
    @(negedge clk); rst = 1'b1;
    checks++;
    if (mem[7] !== pre7 || mem[6] !== stim[6]) begin
      errors++;
      $display("FAIL rstmid_partial: ram7=%h ram6=%h, required %h %h", mem[7], mem[6], pre7, stim[6]);
    end
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
    drive_run(1'b0, -1, -1, cyc, acc, ab);
    check_done("reload", cyc, DEPTH * LOAD_CYCLES_PER_BYTE, acc);
    check_image("reload", DEPTH);
  endtask

  task automatic test_start_mid();
    int cyc, acc;
    bit ab;
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
    drive_run(1'b0, 4, -1, cyc, acc, ab);
    check_done("startmid", cyc, DEPTH * LOAD_CYCLES_PER_BYTE, acc);
    check_image("startmid", DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_stream();
    test_throttled();
    test_verify_err();
    test_reset_mid();
    test_start_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
